vram_arbiter: RTL and testbench

- Shares the single read/write port (port 1) of the 2 KB nametable VRAM between two requesters: the PPU background/render fetch pipeline and the CPU PPUDATA path.
- Folds the 4 KB logical nametable space ($2000-$2FFF, 12-bit offset) onto 2 KB of physical VRAM according to the cartridge mirroring mode.
- Render fetches have priority. A CPU access waits for a free slot, or is forced through after MAX_WAIT clock-enabled cycles.

---
 rtl/ppu_pkg.sv | 42 ++++
 rtl/nt_mirror_map.sv | 25 ++
 rtl/vram_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_vram_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// ---------------------------------------------------------------------------
// ppu_pkg
//   Shared types and constants for the PPU nametable VRAM path.
//
//   mirror_t     cartridge nametable mirroring mode (matches the 2-bit
//                mirror_mode encoding driven by the mapper)
//   arb_state_t  CPU-side state of the VRAM port arbiter
//   NT_OFFSET_W  width of a logical nametable offset ($2000-$2FFF -> 12 bits)
//   nt_bank()    selects which 1 KB physical bank a logical offset lands in
// ---------------------------------------------------------------------------
package ppu_pkg;

   localparam int NT_OFFSET_W = 12;

   typedef enum logic [1:0] {
      MIR_HORIZ    = 2'd0,
      MIR_VERT     = 2'd1,
      MIR_SINGLE_A = 2'd2,
      MIR_SINGLE_B = 2'd3
   } mirror_t;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_PEND = 1'b1
   } arb_state_t;

   // Horizontal mirroring pairs $2000/$2400 and $2800/$2C00, so the top
   // offset bit picks the bank; vertical pairs $2000/$2800, so bit 10 does.
   function automatic logic nt_bank(input logic [NT_OFFSET_W-1:0] offset,
                                    input mirror_t                 mode);
      logic bank;
      case (mode)
         MIR_HORIZ:    bank = offset[11];
         MIR_VERT:     bank = offset[10];
         MIR_SINGLE_A: bank = 1'b0;
         MIR_SINGLE_B: bank = 1'b1;
         default:      bank = 1'b0;
      endcase
      return bank;
   endfunction

endpackage

// File: rtl/nt_mirror_map.sv
// ---------------------------------------------------------------------------
// nt_mirror_map
//   Folds a 12-bit logical nametable offset onto the 2 KB physical VRAM
//   according to the current mirroring mode. Purely combinational.
//
//   Ports:
//     offset  in   NT_OFFSET_W  logical nametable offset (PPU addr[11:0])
//     mode    in   mirror_t     mirroring mode
//     phys    out  VRAM_AW      physical VRAM address {bank, offset[9:0]}
// ---------------------------------------------------------------------------
module nt_mirror_map
   import ppu_pkg::*;
#(
   parameter int VRAM_AW = 11
) (
   input  logic [NT_OFFSET_W-1:0] offset,
   input  mirror_t                mode,
   output logic [VRAM_AW-1:0]     phys
);

   // Each 1 KB logical nametable keeps its low 10 bits; only the bank bit
   // depends on the mirroring mode.
   assign phys = VRAM_AW'({nt_bank(offset, mode), offset[9:0]});

endmodule

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//   Shares port 1 of the 2 KB nametable VRAM between the render fetch
//   pipeline and the CPU PPUDATA path. Render fetches win by default; a
//   pending CPU access takes any cycle render leaves free, and after
//   MAX_WAIT clock-enabled ticks of waiting it preempts render outright.
//   All state advances only on clk edges where clk_en is high.
//
//   Ports:
//     clk, rst_n     master clock, asynchronous active-low reset
//     clk_en         PPU clock enable
//     mirror_mode    0 horiz, 1 vert, 2 single-A, 3 single-B
//     render_req     render fetch request for this tick
//     render_addr    render nametable offset
//     render_data    registered fetch data
//     render_valid   render_data updated at the last clk_en edge
//     render_drop    last render request was preempted by the CPU
//     cpu_req        CPU access request (accepted only while idle)
//     cpu_we         1 = write, 0 = read
//     cpu_addr       CPU nametable offset
//     cpu_wdata      CPU write data
//     cpu_busy       a CPU access is pending
//     cpu_done       CPU access completed at the last clk_en edge
//     cpu_rdata      registered CPU read data, valid with cpu_done
//     vram_addr      VRAM addr1 (combinational)
//     vram_we        VRAM we1 (combinational, gated by clk_en)
//     vram_wdata     VRAM data_in1
//     vram_rdata     VRAM data_out1 (combinational read)
// ---------------------------------------------------------------------------
module vram_arbiter
   import ppu_pkg::*;
#(
   parameter int MAX_WAIT = 7,
   parameter int WAIT_W   = 3,
   parameter int VRAM_AW  = 11
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clk_en,
   input  logic [1:0]             mirror_mode,

   input  logic                   render_req,
   input  logic [NT_OFFSET_W-1:0] render_addr,
   output logic [7:0]             render_data,
   output logic                   render_valid,
   output logic                   render_drop,

   input  logic                   cpu_req,
   input  logic                   cpu_we,
   input  logic [NT_OFFSET_W-1:0] cpu_addr,
   input  logic [7:0]             cpu_wdata,
   output logic                   cpu_busy,
   output logic                   cpu_done,
   output logic [7:0]             cpu_rdata,

   output logic [VRAM_AW-1:0]     vram_addr,
   output logic                   vram_we,
   output logic [7:0]             vram_wdata,
   input  logic [7:0]             vram_rdata
);

   mirror_t                mode;
   arb_state_t             state;
   arb_state_t             state_next;
   logic                   accept;
   logic                   pend;
   logic                   at_max;
   logic                   cpu_grant;
   logic                   render_serve;
   logic [WAIT_W-1:0]      wait_cnt;

   logic                   we_q;
   logic [NT_OFFSET_W-1:0] addr_q;
   logic [7:0]             wdata_q;

   logic [VRAM_AW-1:0]     render_phys;
   logic [VRAM_AW-1:0]     cpu_phys;

   assign mode = mirror_t'(mirror_mode);

   // Mapping is applied combinationally on both sides so a mirroring
   // change takes effect on the very next access, including one already
   // pending.
   nt_mirror_map #(.VRAM_AW(VRAM_AW)) u_map_render (
      .offset (render_addr),
      .mode   (mode),
      .phys   (render_phys)
   );

   nt_mirror_map #(.VRAM_AW(VRAM_AW)) u_map_cpu (
      .offset (addr_q),
      .mode   (mode),
      .phys   (cpu_phys)
   );

   assign pend     = (state == ARB_PEND);
   assign cpu_busy = pend;
   assign at_max   = (wait_cnt == WAIT_W'(MAX_WAIT));

   // The CPU owns the port whenever render is quiet, or once it has waited
   // long enough that render is starved out for one tick.
   assign cpu_grant    = pend & (~render_req | at_max);
   assign render_serve = render_req & ~cpu_grant;

   assign vram_addr  = cpu_grant ? cpu_phys : render_phys;
   assign vram_we    = cpu_grant & we_q & clk_en;
   assign vram_wdata = wdata_q;

   // State register: IDLE/PEND tracks whether a CPU access is outstanding.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ARB_IDLE;
      end else if (clk_en) begin
         state <= state_next;
      end
   end

   // Next state. A request is only taken from IDLE, so the completion edge
   // (still PEND) can never accept, which enforces the two-tick spacing.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (cpu_req) begin
               state_next = ARB_PEND;
               accept     = 1'b1;
            end
         end
         ARB_PEND: begin
            if (cpu_grant) begin
               state_next = ARB_IDLE;
            end
         end
         default: begin
            state_next = ARB_IDLE;
         end
      endcase
   end

   // Latched CPU request fields and the starvation counter. Fields only
   // load on accept, so requests seen while busy cannot disturb them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wait_cnt <= '0;
      end else if (clk_en) begin
         if (accept) begin
            we_q     <= cpu_we;
            addr_q   <= cpu_addr;
            wdata_q  <= cpu_wdata;
            wait_cnt <= '0;
         end else if (pend && !cpu_grant && !at_max) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
      end
   end

   // Result registers. The valid/drop/done flags are recomputed every tick
   // so they behave as single-tick pulses; a drop is flagged only when the
   // CPU actually took a tick that render had asked for.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         render_data  <= '0;
         render_valid <= 1'b0;
         render_drop  <= 1'b0;
         cpu_rdata    <= '0;
         cpu_done     <= 1'b0;
      end else if (clk_en) begin
         render_valid <= render_serve;
         render_drop  <= render_req & cpu_grant;
         cpu_done     <= cpu_grant;
         if (render_serve) begin
            render_data <= vram_rdata;
         end
         if (cpu_grant && !we_q) begin
            cpu_rdata <= vram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_arbiter
//   Directed bench for vram_arbiter with a behavioural 2 KB VRAM attached to
//   port 1. Expected read data is queued when a request is driven and
//   compared when the arbiter reports completion.
// ---------------------------------------------------------------------------
module tb_vram_arbiter;

   logic        clk;
   logic        rst_n;
   logic        clk_en;
   logic [1:0]  mirror_mode;
   logic        render_req;
   logic [11:0] render_addr;
   logic [7:0]  render_data;
   logic        render_valid;
   logic        render_drop;
   logic        cpu_req;
   logic        cpu_we;
   logic [11:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_busy;
   logic        cpu_done;
   logic [7:0]  cpu_rdata;
   logic [10:0] vram_addr;
   logic        vram_we;
   logic [7:0]  vram_wdata;
   logic [7:0]  vram_rdata;

   // Behavioural VRAM plus a bench-side preload port.
   logic [7:0]  mem [0:2047];
   logic        pre_we;
   logic [10:0] pre_addr;
   logic [7:0]  pre_data;

   int          n_cmp;
   int          n_err;
   logic [7:0]  cpu_q [$];
   logic [7:0]  rnd_q [$];

   vram_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clk_en       (clk_en),
      .mirror_mode  (mirror_mode),
      .render_req   (render_req),
      .render_addr  (render_addr),
      .render_data  (render_data),
      .render_valid (render_valid),
      .render_drop  (render_drop),
      .cpu_req      (cpu_req),
      .cpu_we       (cpu_we),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_busy     (cpu_busy),
      .cpu_done     (cpu_done),
      .cpu_rdata    (cpu_rdata),
      .vram_addr    (vram_addr),
      .vram_we      (vram_we),
      .vram_wdata   (vram_wdata),
      .vram_rdata   (vram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign vram_rdata = mem[vram_addr];

   always @(posedge clk) begin
      if (vram_we) begin
         mem[vram_addr] <= vram_wdata;
      end else if (pre_we) begin
         mem[pre_addr] <= pre_data;
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pop_cpu(input string tag);
      logic [7:0] e;
      if (cpu_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("[TB] FAIL %s: observed=%0h expected=<empty scoreboard>", tag, cpu_rdata);
      end else begin
         e = cpu_q.pop_front();
         check(tag, {24'd0, cpu_rdata}, {24'd0, e});
      end
   endtask

   task automatic pop_rnd(input string tag);
      logic [7:0] e;
      if (rnd_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("[TB] FAIL %s: observed=%0h expected=<empty scoreboard>", tag, render_data);
      end else begin
         e = rnd_q.pop_front();
         check(tag, {24'd0, render_data}, {24'd0, e});
      end
   endtask

   // One PPU tick: clk_en high for one master clock, low for three.
   task automatic tick();
      @(negedge clk);
      clk_en = 1'b1;
      @(negedge clk);
      clk_en = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic preload(input logic [10:0] a, input logic [7:0] d);
      pre_we   = 1'b1;
      pre_addr = a;
      pre_data = d;
      @(negedge clk);
      pre_we   = 1'b0;
   endtask

   // CPU write with render idle: completes one tick after accept.
   task automatic cpu_write_idle(input string tag, input logic [1:0] mode,
                                 input logic [11:0] addr, input logic [7:0] data,
                                 input logic [10:0] phys);
      mirror_mode = mode;
      render_req  = 1'b0;
      cpu_req     = 1'b1;
      cpu_we      = 1'b1;
      cpu_addr    = addr;
      cpu_wdata   = data;
      tick();
      cpu_req = 1'b0;
      cpu_we  = 1'b0;
      check({tag, "_busy"}, 32'(cpu_busy), 32'd1);
      check({tag, "_done0"}, 32'(cpu_done), 32'd0);
      check({tag, "_we_gated"}, 32'(vram_we), 32'd0);
      check({tag, "_addr"}, 32'(vram_addr), 32'(phys));
      tick();
      check({tag, "_done"}, 32'(cpu_done), 32'd1);
      check({tag, "_idle"}, 32'(cpu_busy), 32'd0);
      check({tag, "_mem"}, 32'(mem[phys]), 32'(data));
      tick();
      check({tag, "_pulse"}, 32'(cpu_done), 32'd0);
   endtask

   task automatic applyStimulus();
      int ticks;
      bit done_seen;

      // Reset and clear VRAM.
      rst_n = 1'b0; clk_en = 1'b0; mirror_mode = 2'd1;
      render_req = 1'b0; render_addr = '0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      for (int a = 0; a < 2048; a++) begin
         preload(a[10:0], 8'h00);
      end
      preload(11'h123, 8'h5C);
      preload(11'h010, 8'h3C);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_render_data", 32'(render_data), 32'd0);
      check("rst_render_valid", 32'(render_valid), 32'd0);
      check("rst_render_drop", 32'(render_drop), 32'd0);
      check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
      check("rst_cpu_done", 32'(cpu_done), 32'd0);
      check("rst_cpu_busy", 32'(cpu_busy), 32'd0);

      // Mirroring of CPU writes to offset $400.
      cpu_write_idle("wr_vert", 2'd1, 12'h400, 8'hA5, 11'h400);
      check("wr_vert_other_bank", 32'(mem[11'h000]), 32'd0);
      cpu_write_idle("wr_horiz", 2'd0, 12'h400, 8'hA5, 11'h000);
      cpu_write_idle("wr_singleB", 2'd3, 12'h400, 8'h96, 11'h400);
      cpu_write_idle("wr_singleA", 2'd2, 12'hC05, 8'h77, 11'h005);

      // Combinational render-side mapping of offset $805 in every mode.
      render_req = 1'b1; render_addr = 12'h805;
      mirror_mode = 2'd0; #1; check("map_horiz", 32'(vram_addr), 32'h405);
      mirror_mode = 2'd1; #1; check("map_vert", 32'(vram_addr), 32'h005);
      mirror_mode = 2'd2; #1; check("map_singleA", 32'(vram_addr), 32'h005);
      mirror_mode = 2'd3; #1; check("map_singleB", 32'(vram_addr), 32'h405);
      render_req = 1'b0; mirror_mode = 2'd1;
      @(negedge clk);

      // Plain render read.
      render_req = 1'b1; render_addr = 12'h123;
      rnd_q.push_back(8'h5C);
      tick();
      render_req = 1'b0;
      check("rd_valid", 32'(render_valid), 32'd1);
      pop_rnd("rd_data");
      tick();
      check("rd_valid_pulse", 32'(render_valid), 32'd0);

      // CPU write that waits behind three render ticks.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h2AB; cpu_wdata = 8'hC3;
      tick();
      cpu_req = 1'b0; cpu_we = 1'b0;
      check("wait_busy0", 32'(cpu_busy), 32'd1);
      render_req = 1'b1; render_addr = 12'h123;
      for (int i = 1; i <= 3; i++) begin
         rnd_q.push_back(8'h5C);
         tick();
         check("wait_busy", 32'(cpu_busy), 32'd1);
         check("wait_valid", 32'(render_valid), 32'd1);
         pop_rnd("wait_rdata");
         check("wait_nocommit", 32'(mem[11'h2AB]), 32'd0);
      end
      render_req = 1'b0;
      tick();
      check("wait_done", 32'(cpu_done), 32'd1);
      check("wait_idle", 32'(cpu_busy), 32'd0);
      check("wait_mem", 32'(mem[11'h2AB]), 32'hC3);
      check("wait_valid_clr", 32'(render_valid), 32'd0);

      // Starvation: render never lets go, CPU read forced after MAX_WAIT.
      render_req = 1'b1; render_addr = 12'h123;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
      cpu_q.push_back(8'h3C);
      rnd_q.push_back(8'h5C);
      tick();
      cpu_req = 1'b0;
      check("starve_busy", 32'(cpu_busy), 32'd1);
      pop_rnd("starve_rdata0");
      ticks = 0;
      done_seen = 1'b0;
      for (int i = 1; i <= 20 && !done_seen; i++) begin
         if (i < 8) rnd_q.push_back(8'h5C);
         tick();
         if (cpu_done) begin
            done_seen = 1'b1;
            ticks = i;
         end else begin
            check("starve_valid", 32'(render_valid), 32'd1);
            pop_rnd("starve_rdata");
         end
      end
      check("starve_latency", 32'(ticks), 32'd8);
      check("starve_drop", 32'(render_drop), 32'd1);
      check("starve_valid_drop", 32'(render_valid), 32'd0);
      pop_cpu("starve_cpu_rdata");
      render_req = 1'b0;
      tick();
      check("starve_drop_pulse", 32'(render_drop), 32'd0);

      // Back-to-back reads with cpu_req held: accept every second tick.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
      cpu_q.push_back(8'h3C);
      tick();
      check("b2b_busy0", 32'(cpu_busy), 32'd1);
      check("b2b_done0", 32'(cpu_done), 32'd0);
      cpu_addr = 12'h123;
      tick();
      check("b2b_done1", 32'(cpu_done), 32'd1);
      check("b2b_busy1", 32'(cpu_busy), 32'd0);
      pop_cpu("b2b_rdata1");
      cpu_q.push_back(8'h5C);
      tick();
      check("b2b_busy2", 32'(cpu_busy), 32'd1);
      check("b2b_done2", 32'(cpu_done), 32'd0);
      tick();
      check("b2b_done3", 32'(cpu_done), 32'd1);
      pop_cpu("b2b_rdata3");
      cpu_req = 1'b0;

      // A request while busy must not overwrite the latched access.
      render_req = 1'b1; render_addr = 12'h123;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
      cpu_q.push_back(8'h3C);
      rnd_q.push_back(8'h5C);
      tick();
      pop_rnd("ovr_rdata0");
      cpu_we = 1'b1; cpu_addr = 12'h123; cpu_wdata = 8'hFF;
      rnd_q.push_back(8'h5C);
      tick();
      pop_rnd("ovr_rdata1");
      cpu_req = 1'b0; cpu_we = 1'b0; render_req = 1'b0;
      tick();
      check("ovr_done", 32'(cpu_done), 32'd1);
      pop_cpu("ovr_cpu_rdata");
      check("ovr_mem_kept", 32'(mem[11'h123]), 32'h5C);

      // Asynchronous reset with a write pending.
      render_req = 1'b1; render_addr = 12'h123;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h0F0; cpu_wdata = 8'hEE;
      rnd_q.push_back(8'h5C);
      tick();
      cpu_req = 1'b0; cpu_we = 1'b0;
      pop_rnd("rstmid_rdata0");
      rnd_q.push_back(8'h5C);
      tick();
      pop_rnd("rstmid_rdata1");
      check("rstmid_pre_busy", 32'(cpu_busy), 32'd1);
      check("rstmid_pre_valid", 32'(render_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rstmid_render_data", 32'(render_data), 32'd0);
      check("rstmid_render_valid", 32'(render_valid), 32'd0);
      check("rstmid_render_drop", 32'(render_drop), 32'd0);
      check("rstmid_cpu_rdata", 32'(cpu_rdata), 32'd0);
      check("rstmid_cpu_done", 32'(cpu_done), 32'd0);
      check("rstmid_cpu_busy", 32'(cpu_busy), 32'd0);
      check("rstmid_vram_we", 32'(vram_we), 32'd0);
      render_req = 1'b0;
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      check("rstmid_mem", 32'(mem[11'h0F0]), 32'd0);
      check("rstmid_post_busy", 32'(cpu_busy), 32'd0);
      check("rstmid_post_done", 32'(cpu_done), 32'd0);
   endtask

   task automatic checkOutput();
      check("sb_cpu_empty", 32'(cpu_q.size()), 32'd0);
      check("sb_rnd_empty", 32'(rnd_q.size()), 32'd0);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      applyStimulus();
      checkOutput();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
